// File: rtl/pipelined_adder.sv
// pipelined_adder
//   WIDTH-bit adder whose carry chain is cut into STAGES equal chunks, one
//   chunk per register stage. Operands travel down the pipe next to the
//   partial sum. A single valid/ready handshake on each side controls it, and
//   the whole pipe stalls together on back-pressure.
//
// Optional feature macro: PIPELINED_ADDER_SUB_EN
//   When defined, the block gets a 'sub' input. With sub=1 it computes
//   a - b - cin as a + ~b + !cin. When undefined, the block adds only.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid        in_ready   pipe can accept (= advance)
//   a, b       WIDTH-bit operands    cin        carry-in (borrow-in for sub)
//   sub        subtract select (only with PIPELINED_ADDER_SUB_EN)
//   out_valid  result valid          out_ready  downstream accepts
//   sum        (a+b+cin) mod 2^WIDTH
//   cout       carry out of MSB      ovf        signed overflow
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // Per-stage pipeline registers. Stage k holds the result chunks 0..k.
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
`ifdef PIPELINED_ADDER_SUB_EN
  logic             sub_q   [STAGES];
  logic             sub_d   [STAGES];
  logic             src_sub [STAGES];
`endif

  // The value feeding each stage: the ports for stage 0, else the previous stage.
  logic             src_valid [STAGES];
  logic [WIDTH-1:0] src_a     [STAGES];
  logic [WIDTH-1:0] src_b     [STAGES];
  logic [WIDTH-1:0] src_sum   [STAGES];
  logic             src_carry [STAGES];

  logic ovf_q, ovf_d;
  logic ready_en_q, ready_en_d;
  logic advance;

  // Global advance. in_ready stays low until the first edge after reset release.
  always_comb begin
    advance    = !valid_q[STAGES-1] || out_ready;
    in_ready   = advance && ready_en_q;
    ready_en_d = 1'b1;
  end

  // Route the inputs of each stage.
  always_comb begin
    src_valid[0] = in_valid && in_ready;
    src_a[0]     = a;
    src_b[0]     = b;
    src_sum[0]   = '0;
`ifdef PIPELINED_ADDER_SUB_EN
    src_sub[0]   = sub;
    // a - b - cin == a + ~b + !cin
    src_carry[0] = cin ^ sub;
`else
    src_carry[0] = cin;
`endif
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_sum[k]   = sum_q[k-1];
      src_carry[k] = carry_q[k-1];
`ifdef PIPELINED_ADDER_SUB_EN
      src_sub[k]   = sub_q[k-1];
`endif
    end
  end

  // Chunk adders. On advance, every stage loads from its source. Otherwise it holds.
  always_comb begin
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             b_msb;
    b_chunk   = '0;
    chunk_sum = '0;
    b_msb     = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
      sum_d[k]   = sum_q[k];
      carry_d[k] = carry_q[k];
`ifdef PIPELINED_ADDER_SUB_EN
      sub_d[k]   = sub_q[k];
`endif
      if (advance) begin
        b_chunk = src_b[k][k*CHUNK +: CHUNK];
`ifdef PIPELINED_ADDER_SUB_EN
        b_chunk  = b_chunk ^ {CHUNK{src_sub[k]}};
        sub_d[k] = src_sub[k];
`endif
        chunk_sum = {1'b0, src_a[k][k*CHUNK +: CHUNK]} + {1'b0, b_chunk}
                  + {{CHUNK{1'b0}}, src_carry[k]};
        valid_d[k] = src_valid[k];
        a_d[k]     = src_a[k];
        b_d[k]     = src_b[k];
        sum_d[k]   = src_sum[k];
        sum_d[k][k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d[k] = chunk_sum[CHUNK];
      end else begin
        valid_d[k] = valid_q[k];
      end
    end

    // Overflow for the last stage only. The carry into the MSB is recovered
    // as a ^ b ^ sum at that bit.
`ifdef PIPELINED_ADDER_SUB_EN
    b_msb = src_b[STAGES-1][WIDTH-1] ^ src_sub[STAGES-1];
`else
    b_msb = src_b[STAGES-1][WIDTH-1];
`endif
    if (advance) begin
      ovf_d = src_a[STAGES-1][WIDTH-1] ^ b_msb ^ sum_d[STAGES-1][WIDTH-1]
            ^ carry_d[STAGES-1];
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
        sub_q[k]   <= 1'b0;
`endif
      end
      ovf_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
`ifdef PIPELINED_ADDER_SUB_EN
        sub_q[k]   <= sub_d[k];
`endif
      end
      ovf_q      <= ovf_d;
      ready_en_q <= ready_en_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule
